// File: rtl/mau_pkg.sv
// Shared definitions for the load/store access unit: op encodings, FSM states
// and the default data-memory size.
package mau_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 12288;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  function automatic logic op_is_store(input op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering: store byte enables / replicated store data, and
// extraction plus sign/zero extension of load data from a memory word.
module mau_lane
  import mau_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    byte_sel = word_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  // Loads always read the full word; only stores narrow the byte enables.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = '0;
    rdata_o = '0;
    unique case (op_i)
      OP_LW:  rdata_o = word_i;
      OP_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: rdata_o = {16'h0000, half_sel};
      OP_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: rdata_o = {24'h000000, byte_sel};
      OP_SW:  wdata_o = wdata_i;
      OP_SH: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      OP_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: checks alignment/range, issues one word-aligned
// byte-enabled memory request, waits for MemAck and returns extended data.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [31:0] PC,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        AdEL,
  output logic        AdES,
  output logic [31:0] ExcPC,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic        err_q, err_d;
  logic        addr_err;

  logic        busy_q, busy_d, done_q, done_d, adel_q, adel_d, ades_q, ades_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  always_comb begin
    addr_err = (Addr >= MEM_BYTES);
    unique case (op_e'(Op))
      OP_LW, OP_SW:         addr_err = addr_err | (Addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: addr_err = addr_err | Addr[0];
      default: ;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    err_d   = err_q;
    if (state_q == ST_IDLE && Req) begin
      op_d    = op_e'(Op);
      addr_d  = Addr;
      wdata_d = WData;
      pc_d    = PC;
      err_d   = addr_err;
    end
  end

  // Lane logic sees the next-cycle request so memory outputs can be registered.
  mau_lane u_lane (
    .op_i      (op_d),
    .addr_lo_i (addr_d[1:0]),
    .wdata_i   (wdata_d),
    .word_i    (MemRData),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (Req) state_d = addr_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (MemAck) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_RESP);
    adel_d      = done_d && err_d && !op_is_store(op_d);
    ades_d      = done_d && err_d && op_is_store(op_d);
    rdata_d     = (state_q == ST_ACCESS && MemAck && !op_is_store(op_q)) ? lane_rdata : '0;
    mem_req_d   = (state_d == ST_ACCESS);
    mem_we_d    = mem_req_d && op_is_store(op_d);
    mem_addr_d  = mem_req_d ? {addr_d[31:2], 2'b00} : '0;
    mem_be_d    = mem_req_d ? lane_be : '0;
    mem_wdata_d = mem_req_d ? lane_wdata : '0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign RData    = rdata_q;
  assign AdEL     = adel_q;
  assign AdES     = ades_q;
  assign ExcPC    = pc_q;
  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemBe    = mem_be_q;
  assign MemWData = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected responses are queued at issue
// and popped when Done is observed.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] Addr = '0, WData = '0, PC = '0, MemRData = '0;
  logic        MemAck = 1'b0;
  logic        Busy, Done, AdEL, AdES, MemReq, MemWe;
  logic [31:0] RData, ExcPC, MemAddr, MemWData;
  logic [3:0]  MemBe;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        adel;
    logic        ades;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_access_unit #(.MEM_BYTES(12288)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .WData(WData), .PC(PC),
    .Busy(Busy), .Done(Done), .RData(RData), .AdEL(AdEL), .AdES(AdES), .ExcPC(ExcPC),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // n = cycle (1-based, counted from MemReq rising) in which MemAck is driven.
  task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc, input int n,
                         input logic [31:0] rword, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd,
                         input logic eadel, input logic eades, input bit hold);
    exp_t e;
    bit   is_store;
    is_store = (op == SW) || (op == SH) || (op == SB);
    e.rdata = erd; e.pc = pc; e.adel = eadel; e.ades = eades;
    sb_q.push_back(e);
    Req = 1'b1; Op = op; Addr = addr; WData = wdata; PC = pc;
    @(negedge Clk);
    if (!hold) Req = 1'b0;
    if (!(eadel || eades)) begin
      for (int i = 1; i <= n; i++) begin
        check({tag, " MemReq"}, {31'b0, MemReq}, 32'd1);
        check({tag, " MemAddr"}, MemAddr, {addr[31:2], 2'b00});
        check({tag, " MemBe"}, {28'b0, MemBe}, {28'b0, ebe});
        check({tag, " MemWe"}, {31'b0, MemWe}, {31'b0, is_store});
        if (is_store) check({tag, " MemWData"}, MemWData, ewd);
        check({tag, " Busy"}, {31'b0, Busy}, 32'd1);
        check({tag, " Done early"}, {31'b0, Done}, 32'd0);
        if (i == n) begin MemAck = 1'b1; MemRData = rword; end
        @(negedge Clk);
      end
      MemAck = 1'b0;
      MemRData = 32'h0BAD_F00D;
    end
    check({tag, " MemReq resp"}, {31'b0, MemReq}, 32'd0);
    check({tag, " Busy resp"}, {31'b0, Busy}, 32'd1);
    check({tag, " Done"}, {31'b0, Done}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " RData"}, RData, e.rdata);
      check({tag, " AdEL"}, {31'b0, AdEL}, {31'b0, e.adel});
      check({tag, " AdES"}, {31'b0, AdES}, {31'b0, e.ades});
      check({tag, " ExcPC"}, ExcPC, e.pc);
    end
    @(negedge Clk);
    Req = 1'b0;
    check({tag, " idle Busy"}, {31'b0, Busy}, 32'd0);
    check({tag, " idle Done"}, {31'b0, Done}, 32'd0);
    check({tag, " idle MemReq"}, {31'b0, MemReq}, 32'd0);
  endtask

  initial begin
    @(negedge Clk);
    check("reset Busy", {31'b0, Busy}, 32'd0);
    check("reset Done", {31'b0, Done}, 32'd0);
    check("reset MemReq", {31'b0, MemReq}, 32'd0);
    check("reset ExcPC", ExcPC, 32'd0);
    check("reset RData", RData, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    run_req("sw 10",   SW,  32'h10, 32'hDEADBEEF, 32'h100, 1, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    run_req("sb 13",   SB,  32'h13, 32'h000000A5, 32'h104, 1, 32'h0, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0);
    run_req("lb 13",   LB,  32'h13, 32'h0, 32'h108, 1, 32'hA5000000, 4'b1111, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b0, 1'b0);
    run_req("lbu 13",  LBU, 32'h13, 32'h0, 32'h10C, 1, 32'hA5000000, 4'b1111, 32'h0, 32'h000000A5, 1'b0, 1'b0, 1'b0);
    run_req("lb 11",   LB,  32'h11, 32'h0, 32'h110, 2, 32'h00007F00, 4'b1111, 32'h0, 32'h0000007F, 1'b0, 1'b0, 1'b0);
    run_req("lh 22",   LH,  32'h22, 32'h0, 32'h114, 1, 32'h80011234, 4'b1111, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 1'b0);
    run_req("lhu 22",  LHU, 32'h22, 32'h0, 32'h118, 1, 32'h80011234, 4'b1111, 32'h0, 32'h00008001, 1'b0, 1'b0, 1'b0);
    run_req("lh 20",   LH,  32'h20, 32'h0, 32'h11C, 1, 32'h80011234, 4'b1111, 32'h0, 32'h00001234, 1'b0, 1'b0, 1'b0);
    run_req("sh 22",   SH,  32'h22, 32'h1234ABCD, 32'h120, 1, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0, 1'b0);
    run_req("sh 20",   SH,  32'h20, 32'h00005566, 32'h124, 1, 32'h0, 4'b0011, 32'h55665566, 32'h0, 1'b0, 1'b0, 1'b0);
    run_req("sb 11",   SB,  32'h11, 32'hFFFFFF3C, 32'h128, 1, 32'h0, 4'b0010, 32'h3C3C3C3C, 32'h0, 1'b0, 1'b0, 1'b0);
    run_req("lw 2ffc", LW,  32'h2FFC, 32'h0, 32'h12C, 1, 32'h11223344, 4'b1111, 32'h0, 32'h11223344, 1'b0, 1'b0, 1'b0);
    run_req("lw err6", LW,  32'h6, 32'h0, 32'h3004, 1, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_req("sh err5", SH,  32'h5, 32'h0, 32'h3008, 1, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    run_req("sw range",SW,  32'h3000, 32'h0, 32'h300C, 1, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    run_req("lbu range",LBU,32'h3001, 32'h0, 32'h3010, 1, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_req("lw slow", LW,  32'h40, 32'h0, 32'h200, 5, 32'h89ABCDEF, 4'b1111, 32'h0, 32'h89ABCDEF, 1'b0, 1'b0, 1'b1);

    // Reset asserted mid-access, stale MemAck held through and after release.
    Req = 1'b1; Op = LW; Addr = 32'h80; PC = 32'h300;
    @(negedge Clk);
    Req = 1'b0;
    check("rst pre MemReq", {31'b0, MemReq}, 32'd1);
    @(negedge Clk);
    MemAck = 1'b1; MemRData = 32'h5555AAAA;
    Reset = 1'b0;
    #1;
    check("rst MemReq", {31'b0, MemReq}, 32'd0);
    check("rst Busy", {31'b0, Busy}, 32'd0);
    check("rst Done", {31'b0, Done}, 32'd0);
    check("rst MemAddr", MemAddr, 32'd0);
    check("rst ExcPC", ExcPC, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("stale ack Busy", {31'b0, Busy}, 32'd0);
    check("stale ack Done", {31'b0, Done}, 32'd0);
    MemAck = 1'b0;
    run_req("lw post", LW, 32'h84, 32'h0, 32'h304, 2, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
